// File: rtl/vga_mon_pkg.sv
// Shared types and default widths for the VGA frame monitor.
package vga_mon_pkg;

  typedef enum logic {
    SEEK_FRAME = 1'b0,
    RUN        = 1'b1
  } phase_e;

  localparam int HCNT_W_DEF = 11;
  localparam int VCNT_W_DEF = 10;
  localparam int SUM_W      = 24;

endpackage

// File: rtl/vga_edge_sync.sv
// Input register for hsync/vsync, polarity normalisation to active-high and
// rising-edge detection (line edge / frame edge).
module vga_edge_sync #(
  parameter bit HSYNC_ACT_LOW = 1'b1,
  parameter bit VSYNC_ACT_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic hsync_i,
  input  logic vsync_i,
  output logic s_vld_o,
  output logic hs_o,
  output logic le_o,
  output logic fe_o
);

  logic hs_raw_q, vs_raw_q, vld_q, hs_prev_q, vs_prev_q;
  logic hs_n, vs_n;

  assign hs_n = hs_raw_q ^ HSYNC_ACT_LOW;
  assign vs_n = vs_raw_q ^ VSYNC_ACT_LOW;

  // Edges are masked until the register holds a real sample, so the reset
  // value of an active-low sync is never mistaken for an assertion.
  assign s_vld_o = vld_q;
  assign hs_o    = vld_q & hs_n;
  assign le_o    = vld_q & hs_n & ~hs_prev_q;
  assign fe_o    = vld_q & vs_n & ~vs_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_raw_q  <= 1'b0;
      vs_raw_q  <= 1'b0;
      vld_q     <= 1'b0;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      hs_raw_q  <= hsync_i;
      vs_raw_q  <= vsync_i;
      vld_q     <= 1'b1;
      hs_prev_q <= hs_o;
      vs_prev_q <= vld_q & vs_n;
    end
  end

endmodule

// File: rtl/vga_frame_monitor.sv
// Receive-side VGA monitor: recovers pixel coordinates, measures line/frame
// timing, checksums each frame and reports timing lock.
module vga_frame_monitor
  import vga_mon_pkg::*;
#(
  parameter int HCNT_W        = HCNT_W_DEF,
  parameter int VCNT_W        = VCNT_W_DEF,
  parameter bit HSYNC_ACT_LOW = 1'b1,
  parameter bit VSYNC_ACT_LOW = 1'b1,
  parameter int LOCK_FRAMES   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              hblank,
  input  logic              vblank,
  input  logic [7:0]        r,
  input  logic [7:0]        g,
  input  logic [7:0]        b,
  output logic              px_valid,
  output logic [HCNT_W-1:0] px_x,
  output logic [VCNT_W-1:0] px_y,
  output logic [HCNT_W-1:0] h_total,
  output logic [HCNT_W-1:0] h_active,
  output logic [HCNT_W-1:0] hsync_w,
  output logic [VCNT_W-1:0] v_total,
  output logic [VCNT_W-1:0] v_active,
  output logic [SUM_W-1:0]  frame_sum,
  output logic              frame_done,
  output logic              locked,
  output logic              ovf
);

  localparam int MW = $clog2(LOCK_FRAMES + 1);
  localparam logic [MW-1:0]     LOCK_N = MW'(LOCK_FRAMES);
  localparam logic [MW-1:0]     MMAX   = '1;
  localparam logic [HCNT_W-1:0] HMAX   = '1;
  localparam logic [VCNT_W-1:0] VMAX   = '1;

  function automatic logic [HCNT_W-1:0] hinc(input logic [HCNT_W-1:0] v, input logic en);
    return (en && v != HMAX) ? v + 1'b1 : v;
  endfunction

  function automatic logic [VCNT_W-1:0] vinc(input logic [VCNT_W-1:0] v, input logic en);
    return (en && v != VMAX) ? v + 1'b1 : v;
  endfunction

  logic s_vld, hs_s, le, fe;
  logic hb_q, vb_q;
  logic [SUM_W-1:0] pix_q;
  logic act_s, hact_s, hs_en;

  vga_edge_sync #(
    .HSYNC_ACT_LOW (HSYNC_ACT_LOW),
    .VSYNC_ACT_LOW (VSYNC_ACT_LOW)
  ) u_edge (
    .clk     (clk),
    .rst     (rst),
    .hsync_i (hsync),
    .vsync_i (vsync),
    .s_vld_o (s_vld),
    .hs_o    (hs_s),
    .le_o    (le),
    .fe_o    (fe)
  );

  // h_active measures the horizontal active window, so it ignores vblank.
  assign act_s  = s_vld & ~hb_q & ~vb_q;
  assign hact_s = s_vld & ~hb_q;
  assign hs_en  = hs_s;

  phase_e state_q, state_d;
  logic   publish;

  logic [HCNT_W-1:0] hcnt_q, hcnt_d, hact_q, hact_d, hsw_q, hsw_d;
  logic [HCNT_W-1:0] ltot_q, ltot_d, lact_q, lact_d, lsw_q, lsw_d, tot_end;
  logic              line_px_q, line_px_d;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d, vact_q, vact_d, v_end, vact_end, y_cur;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic              ovf_acc_q, ovf_acc_d, ovf_evt;
  logic [MW-1:0]     match_q, match_d;
  logic              same;

  logic              px_valid_q, px_valid_d;
  logic [HCNT_W-1:0] px_x_q, px_x_d, h_total_q, h_total_d, h_active_q, h_active_d;
  logic [HCNT_W-1:0] hsync_w_q, hsync_w_d;
  logic [VCNT_W-1:0] px_y_q, px_y_d, v_total_q, v_total_d, v_active_q, v_active_d;
  logic [SUM_W-1:0]  frame_sum_q, frame_sum_d;
  logic              frame_done_q, frame_done_d, locked_q, locked_d, ovf_q, ovf_d;

  always_comb begin
    state_d = state_q;
    publish = 1'b0;
    unique case (state_q)
      SEEK_FRAME: if (fe) state_d = RUN;
      RUN:        publish = fe;
    endcase
  end

  always_comb begin
    hcnt_d = hcnt_q;  hact_d = hact_q;  hsw_d = hsw_q;  line_px_d = line_px_q;
    ltot_d = ltot_q;  lact_d = lact_q;  lsw_d = lsw_q;
    vcnt_d = vcnt_q;  vact_d = vact_q;  sum_d = sum_q;
    match_d = match_q;  ovf_evt = 1'b0;  same = 1'b0;
    px_valid_d = act_s;  px_x_d = px_x_q;  px_y_d = px_y_q;
    h_total_d = h_total_q;  h_active_d = h_active_q;  hsync_w_d = hsync_w_q;
    v_total_d = v_total_q;  v_active_d = v_active_q;  frame_sum_d = frame_sum_q;
    frame_done_d = 1'b0;  locked_d = locked_q;  ovf_d = ovf_q;
    tot_end = hinc(hcnt_q, 1'b1);

    // Line end is resolved first; the LE cycle itself opens the new line.
    if (le) begin
      ltot_d    = tot_end;
      lact_d    = hact_q;
      lsw_d     = hsw_q;
      hcnt_d    = '0;
      hact_d    = HCNT_W'(hact_s);
      hsw_d     = HCNT_W'(hs_en);
      line_px_d = act_s;
      vcnt_d    = vinc(vcnt_q, 1'b1);
      vact_d    = vinc(vact_q, line_px_q);
      ovf_evt   = (hcnt_q == HMAX) | (vcnt_q == VMAX) | (line_px_q & (vact_q == VMAX));
    end else begin
      hcnt_d    = hinc(hcnt_q, 1'b1);
      hact_d    = hinc(hact_q, hact_s);
      hsw_d     = hinc(hsw_q, hs_en);
      line_px_d = line_px_q | act_s;
      ovf_evt   = (hcnt_q == HMAX) | (hact_s & (hact_q == HMAX)) | (hs_en & (hsw_q == HMAX));
    end
    v_end    = vcnt_d;
    vact_end = vact_d;
    y_cur    = fe ? '0 : vact_d;

    if (act_s) begin
      px_x_d = px_valid_q ? hinc(px_x_q, 1'b1) : '0;
      px_y_d = y_cur;
      sum_d  = sum_q + pix_q;
    end

    ovf_acc_d = ovf_acc_q | ovf_evt;
    if (fe) begin
      vcnt_d    = '0;
      vact_d    = '0;
      sum_d     = act_s ? pix_q : '0;
      ovf_acc_d = 1'b0;
    end

    if (publish) begin
      h_total_d    = le ? tot_end : ltot_q;
      h_active_d   = le ? hact_q : lact_q;
      hsync_w_d    = le ? hsw_q : lsw_q;
      v_total_d    = v_end;
      v_active_d   = vact_end;
      frame_sum_d  = sum_q;
      ovf_d        = ovf_acc_q | ovf_evt;
      frame_done_d = 1'b1;
      same = (h_total_d == h_total_q) && (h_active_d == h_active_q) &&
             (v_total_d == v_total_q) && (v_active_d == v_active_q);
      match_d  = (same && !ovf_d) ? ((match_q == MMAX) ? match_q : match_q + 1'b1) : MW'(1);
      locked_d = (match_d >= LOCK_N);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_q <= 1'b0;  vb_q <= 1'b0;  pix_q <= '0;
      state_q <= SEEK_FRAME;
      hcnt_q <= '0;  hact_q <= '0;  hsw_q <= '0;  line_px_q <= 1'b0;
      ltot_q <= '0;  lact_q <= '0;  lsw_q <= '0;
      vcnt_q <= '0;  vact_q <= '0;  sum_q <= '0;  ovf_acc_q <= 1'b0;  match_q <= '0;
      px_valid_q <= 1'b0;  px_x_q <= '0;  px_y_q <= '0;
      h_total_q <= '0;  h_active_q <= '0;  hsync_w_q <= '0;
      v_total_q <= '0;  v_active_q <= '0;  frame_sum_q <= '0;
      frame_done_q <= 1'b0;  locked_q <= 1'b0;  ovf_q <= 1'b0;
    end else begin
      hb_q <= hblank;  vb_q <= vblank;  pix_q <= {b, g, r};
      state_q <= state_d;
      hcnt_q <= hcnt_d;  hact_q <= hact_d;  hsw_q <= hsw_d;  line_px_q <= line_px_d;
      ltot_q <= ltot_d;  lact_q <= lact_d;  lsw_q <= lsw_d;
      vcnt_q <= vcnt_d;  vact_q <= vact_d;  sum_q <= sum_d;  ovf_acc_q <= ovf_acc_d;
      match_q <= match_d;
      px_valid_q <= px_valid_d;  px_x_q <= px_x_d;  px_y_q <= px_y_d;
      h_total_q <= h_total_d;  h_active_q <= h_active_d;  hsync_w_q <= hsync_w_d;
      v_total_q <= v_total_d;  v_active_q <= v_active_d;  frame_sum_q <= frame_sum_d;
      frame_done_q <= frame_done_d;  locked_q <= locked_d;  ovf_q <= ovf_d;
    end
  end

  assign px_valid   = px_valid_q;
  assign px_x       = px_x_q;
  assign px_y       = px_y_q;
  assign h_total    = h_total_q;
  assign h_active   = h_active_q;
  assign hsync_w    = hsync_w_q;
  assign v_total    = v_total_q;
  assign v_active   = v_active_q;
  assign frame_sum  = frame_sum_q;
  assign frame_done = frame_done_q;
  assign locked     = locked_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor: an active-low-sync instance and an
// active-high-sync instance driven by the same logical timing.
module tb_vga_frame_monitor;

  logic clk = 1'b0;
  logic rst;
  logic hs, vs, hb, vb;
  logic [7:0] r, g, b;

  logic        px_valid, frame_done, locked, ovf;
  logic [10:0] px_x, h_total, h_active, hsync_w;
  logic [9:0]  px_y, v_total, v_active;
  logic [23:0] frame_sum;

  logic        p_px_valid, p_frame_done, p_locked, p_ovf;
  logic [10:0] p_px_x, p_h_total, p_h_active, p_hsync_w;
  logic [9:0]  p_px_y, p_v_total, p_v_active;
  logic [23:0] p_frame_sum;

  always #5 clk = ~clk;

  vga_frame_monitor #(.HSYNC_ACT_LOW(1'b1), .VSYNC_ACT_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .hsync(~hs), .vsync(~vs), .hblank(hb), .vblank(vb),
    .r(r), .g(g), .b(b), .px_valid(px_valid), .px_x(px_x), .px_y(px_y),
    .h_total(h_total), .h_active(h_active), .hsync_w(hsync_w),
    .v_total(v_total), .v_active(v_active), .frame_sum(frame_sum),
    .frame_done(frame_done), .locked(locked), .ovf(ovf)
  );

  vga_frame_monitor #(.HSYNC_ACT_LOW(1'b0), .VSYNC_ACT_LOW(1'b0)) dut_pos (
    .clk(clk), .rst(rst), .hsync(hs), .vsync(vs), .hblank(hb), .vblank(vb),
    .r(r), .g(g), .b(b), .px_valid(p_px_valid), .px_x(p_px_x), .px_y(p_px_y),
    .h_total(p_h_total), .h_active(p_h_active), .hsync_w(p_hsync_w),
    .v_total(p_v_total), .v_active(p_v_active), .frame_sum(p_frame_sum),
    .frame_done(p_frame_done), .locked(p_locked), .ovf(p_ovf)
  );

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  bit chk_px = 1'b0;
  bit pv_exp = 1'b0;
  int px_exp = 0;
  int py_exp = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    hs = 1'b0; vs = 1'b0; hb = 1'b1; vb = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Frame layout: 8 lines, vsync on lines 0-1, vblank on lines 0-2,
  // hsync on columns 0-2, active columns 6-17.
  task automatic drive(input int l, input int c, input bit ramp);
    bit act;
    act = (l >= 3) && (c >= 6) && (c < 18);
    hs = (c < 3);
    vs = (l < 2);
    hb = !((c >= 6) && (c < 18));
    vb = (l < 3);
    if (ramp) {b, g, r} = 24'(act ? c - 6 : 0);
    else begin r = 8'h03; g = 8'h02; b = 8'h01; end
    tick();
    if (frame_done) done_cnt++;
    if (chk_px) begin
      check("px_valid", 32'(px_valid), 32'(pv_exp));
      if (pv_exp) begin
        check("px_x", 32'(px_x), px_exp);
        check("px_y", 32'(px_y), py_exp);
      end
    end
    pv_exp = act;
    px_exp = c - 6;
    py_exp = l - 3;
  endtask

  task automatic send_frame(input int htot, input int last_htot, input bit ramp,
                            input int exp_done, input string tag);
    done_cnt = 0;
    for (int l = 0; l < 8; l++)
      for (int c = 0; c < ((l == 7) ? last_htot : htot); c++)
        drive(l, c, ramp);
    check({tag, "_done"}, done_cnt, exp_done);
  endtask

  initial begin
    rst = 1'b1;
    hs = 1'b0; vs = 1'b0; hb = 1'b1; vb = 1'b1; r = '0; g = '0; b = '0;
    idle(3);
    check("rst_h_total", 32'(h_total), 0);
    check("rst_v_total", 32'(v_total), 0);
    check("rst_frame_sum", 32'(frame_sum), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_px_valid", 32'(px_valid), 0);
    rst = 1'b0;
    idle(5);

    // Basic measurement, constant colour
    send_frame(20, 20, 1'b0, 0, "f1");
    send_frame(20, 20, 1'b0, 1, "f2");
    check("f2_h_total", 32'(h_total), 20);
    check("f2_h_active", 32'(h_active), 12);
    check("f2_hsync_w", 32'(hsync_w), 3);
    check("f2_v_total", 32'(v_total), 8);
    check("f2_v_active", 32'(v_active), 5);
    check("f2_frame_sum", 32'(frame_sum), 32'h3C78B4);
    check("f2_locked", 32'(locked), 0);
    check("f2_ovf", 32'(ovf), 0);
    check("pos_h_total", 32'(p_h_total), 20);
    check("pos_h_active", 32'(p_h_active), 12);
    check("pos_hsync_w", 32'(p_hsync_w), 3);
    check("pos_v_total", 32'(p_v_total), 8);
    check("pos_v_active", 32'(p_v_active), 5);
    check("pos_frame_sum", 32'(p_frame_sum), 32'h3C78B4);

    // Ramp frame with per-pixel coordinate checks
    chk_px = 1'b1;
    send_frame(20, 20, 1'b1, 1, "f3");
    chk_px = 1'b0;
    check("f3_locked", 32'(locked), 1);
    check("f3_frame_sum", 32'(frame_sum), 32'h3C78B4);

    // Line length change breaks lock
    send_frame(22, 22, 1'b0, 1, "f4");
    check("f4_frame_sum", 32'(frame_sum), 32'h00014A);
    check("f4_locked", 32'(locked), 1);
    send_frame(20, 20, 1'b0, 1, "f5");
    check("f5_h_total", 32'(h_total), 22);
    check("f5_locked", 32'(locked), 0);

    // Overlong last line saturates the horizontal counter
    send_frame(20, 2100, 1'b0, 1, "f6");
    check("f6_h_total", 32'(h_total), 20);
    check("f6_ovf", 32'(ovf), 0);
    send_frame(20, 20, 1'b0, 1, "f7");
    check("f7_h_total", 32'(h_total), 32'h7FF);
    check("f7_ovf", 32'(ovf), 1);
    check("f7_locked", 32'(locked), 0);
    check("f7_v_total", 32'(v_total), 8);
    send_frame(20, 20, 1'b0, 1, "f8");
    check("f8_ovf", 32'(ovf), 0);
    check("f8_h_total", 32'(h_total), 20);

    // Reset in the middle of an active line
    for (int c = 0; c < 20; c++) drive(3, c, 1'b0);
    for (int c = 0; c < 15; c++) drive(4, c, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_h_total", 32'(h_total), 0);
    check("mid_v_active", 32'(v_active), 0);
    check("mid_frame_sum", 32'(frame_sum), 0);
    check("mid_px_valid", 32'(px_valid), 0);
    check("mid_px_x", 32'(px_x), 0);
    check("mid_px_y", 32'(px_y), 0);
    idle(3);
    rst = 1'b0;
    idle(5);
    send_frame(20, 20, 1'b0, 0, "f10");
    send_frame(20, 20, 1'b0, 1, "f11");
    check("f11_h_total", 32'(h_total), 20);
    check("f11_v_total", 32'(v_total), 8);
    check("f11_v_active", 32'(v_active), 5);
    check("f11_frame_sum", 32'(frame_sum), 32'h3C78B4);
    check("f11_locked", 32'(locked), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_frame_monitor.md
Name: vga_frame_monitor

Overview:
Receive-side companion to the VGA pattern controller. It samples hsync/vsync/hblank/vblank and the 24-bit RGB bus on the same clock and recovers pixel coordinates. Per frame it measures horizontal and vertical timing, accumulates a pixel checksum, and reports timing lock. It is used on-chip as a loopback self-check of the DAC-facing RGB bus, and in benches as the scoreboard front end.

Parameters:
HCNT_W, 11, width of horizontal counters and measurements (clocks per line).
VCNT_W, 10, width of vertical counters and measurements (lines per frame).
HSYNC_ACT_LOW, 1, 1 = hsync asserted when low.
VSYNC_ACT_LOW, 1, 1 = vsync asserted when low.
LOCK_FRAMES, 2, consecutive identical frame measurements needed to assert locked (min 2).

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous reset, active-high
hsync  in  1  horizontal sync, polarity per HSYNC_ACT_LOW
vsync  in  1  vertical sync, polarity per VSYNC_ACT_LOW
hblank  in  1  high outside the active horizontal region
vblank  in  1  high outside the active vertical region
r, g, b  in  8 each  colour channels
px_valid  out  1  registered pixel is active
px_x  out  HCNT_W  column of the registered pixel
px_y  out  VCNT_W  row of the registered pixel
h_total  out  HCNT_W  clocks per line
h_active  out  HCNT_W  active clocks per line
hsync_w  out  HCNT_W  hsync-asserted clocks per line
v_total  out  VCNT_W  lines per frame
v_active  out  VCNT_W  lines containing at least one active pixel
frame_sum  out  24  checksum of the last frame
frame_done  out  1  one-clock pulse when the measurement outputs update
locked  out  1  timing stable
ovf  out  1  a counter saturated in the last frame

Behaviour:
- Input stage: every input is registered once (stage S). Sync signals are normalised to active-high after the register.
- Line edge (LE): S-hsync rises.
- Frame edge (FE): S-vsync rises.
- Active pixel: S-hblank=0 and S-vblank=0.
- Reset: all outputs and internal state go to 0. This includes locked, ovf and frame_done.
- Phase state machine: states SEEK_FRAME and RUN.
  - After reset the block is in SEEK_FRAME. The first FE only moves it to RUN and clears the accumulators. No frame_done is issued for that partial frame.
  - In RUN, every FE publishes the measurements.
- Horizontal counting: hcnt counts clocks since the last LE.
  - On LE, the line's hcnt+1 is stored as the line total, then hcnt restarts at 0.
  - The line's active-clock count and hsync-asserted count are stored alongside the total.
  - Published h_* values are those of the last complete line before the FE.
- Vertical counting:
  - vcnt increments on each LE; FE clears it.
  - A line counts toward v_active if it contained at least one active pixel.
- Simultaneous LE and FE: the line end is processed first. It counts in v_total, and its h values are published. Then the frame end is processed.
- Coordinates:
  - px_valid is registered from the active condition, one clock after S.
  - px_x is 0 on the first active pixel after hblank and increments per active pixel.
  - px_y is 0 at FE and increments at the end of each line that had active pixels.
- Checksum: on each active pixel, frame_sum_acc += {b,g,r}, modulo 2^24.
- Publish timing: all published outputs update together, one clock after S shows the FE. frame_done is high in that same cycle. Accumulators clear in the same cycle.
- Saturation: hcnt, vcnt and the per-line counters saturate at all-ones and never wrap.
  - Any saturation sets an internal overflow flag.
  - ovf is published at FE and cleared by the next clean frame.
- Lock:
  - match_cnt increments at each FE where (h_total, h_active, v_total, v_active) equal the previously published values and ovf is 0. Otherwise it resets to 1.
  - locked = match_cnt >= LOCK_FRAMES. It drops on the same FE that mismatches.
- Reset mid-frame: rst takes effect immediately. Operation resumes in SEEK_FRAME, and no output glitches beyond the reset values.

Decomposition:
- Shared package vga_mon_pkg holds:
  - the phase-state enum (SEEK_FRAME, RUN);
  - default widths HCNT_W/VCNT_W;
  - the checksum width of 24.
- One sub-module, vga_edge_sync, holds the input register, polarity normalisation and edge detection for hsync and vsync.
- Everything else is flat.

Test Plan:
- Tiny timing: h_total 20, h_active 12, hsync 3, v_total 8, v_active 5, constant RGB r=0x03 g=0x02 b=0x01. Expected: after the 2nd FE, h_total=20, h_active=12, hsync_w=3, v_total=8, v_active=5, frame_sum=0x3C78B4 (0x010203*60), and frame_done pulses exactly once per frame with none at the 1st FE.
- Same timing with a ramp pixel {b,g,r}=px_x. Expected: px_x runs 0..11 and px_y 0..4 with px_valid aligned, and frame_sum=5*66=0x00014A.
- Three identical frames, then h_total changed to 22. Expected: locked rises at the 3rd FE (2 published matches) and falls at the FE of the first 22-clock frame.
- Hold hsync deasserted for more than 2^HCNT_W clocks. Expected: hcnt saturates at 2047, ovf=1 at the next FE, locked=0, and ovf clears after the next clean frame.
- HSYNC_ACT_LOW=0, VSYNC_ACT_LOW=0 with inverted sync stimulus. Expected: measurements identical to the first scenario.
- rst pulsed mid-frame. Expected: all outputs are 0 immediately, no frame_done at the next FE, and correct values at the following FE.
